// File: rtl/result_display_scan_if.sv
// Result handshake between the ALU result register (master) and the display scanner (slave).
interface result_display_scan_if #(
  parameter int DIGIT_NUM = 8
);
  logic                     load;
  logic [DIGIT_NUM*4-1:0]   value;
  logic                     value_sign;
  logic [2:0]               value_dp;
  logic                     ready;
  logic                     err;

  modport master (
    output load, value, value_sign, value_dp,
    input  ready, err
  );

  modport slave (
    input  load, value, value_sign, value_dp,
    output ready, err
  );
endinterface

// File: rtl/result_display_scan.sv
// BCD result to multiplexed 7-segment display: per-digit analysis of each loaded value,
// atomic frame commit, and a free-running digit scan.
module result_display_scan #(
  parameter int DIGIT_NUM   = 8,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  result_display_scan_if.slave  rif,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGIT_NUM-1:0]  digit_en
);

  localparam int IDX_W = (DIGIT_NUM > 1) ? $clog2(DIGIT_NUM) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, ANALYZE, COMMIT} state_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'h3F;
      4'd1:    bcd_to_seg = 7'h06;
      4'd2:    bcd_to_seg = 7'h5B;
      4'd3:    bcd_to_seg = 7'h4F;
      4'd4:    bcd_to_seg = 7'h66;
      4'd5:    bcd_to_seg = 7'h6D;
      4'd6:    bcd_to_seg = 7'h7D;
      4'd7:    bcd_to_seg = 7'h07;
      4'd8:    bcd_to_seg = 7'h7F;
      4'd9:    bcd_to_seg = 7'h6F;
      default: bcd_to_seg = 7'h00;
    endcase
  endfunction

  state_t                     state_q, state_d;
  logic                       ready_q, ready_d;
  logic                       err_q, err_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [IDX_W-1:0]           msd_q, msd_d;
  logic                       found_q, found_d;
  logic                       bad_q, bad_d;
  logic [DIGIT_NUM*4-1:0]     sh_value_q, sh_value_d;
  logic                       sh_sign_q, sh_sign_d;
  logic [2:0]                 sh_dp_q, sh_dp_d;
  logic [DIGIT_NUM-1:0][6:0]  frame_seg_q, frame_seg_d;
  logic [DIGIT_NUM-1:0]       frame_dp_q, frame_dp_d;

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           scan_q, scan_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       seg_dp_q, seg_dp_d;
  logic [DIGIT_NUM-1:0]       digit_en_q, digit_en_d;

  logic [3:0]                 nib;
  logic [DIGIT_NUM-1:0][6:0]  new_seg;
  logic [DIGIT_NUM-1:0]       new_dp;
  logic                       neg;
  logic                       frame_error;
  int                         top;

  // Frame built from the analysis results; only latched into the frame registers in COMMIT.
  always_comb begin
    top         = (int'(msd_q) > int'(sh_dp_q)) ? int'(msd_q) : int'(sh_dp_q);
    neg         = sh_sign_q & found_q;
    frame_error = bad_q | (neg & (top == DIGIT_NUM - 1));
    new_seg     = '0;
    new_dp      = '0;
    for (int i = 0; i < DIGIT_NUM; i++) begin
      if (frame_error) begin
        if (i == DIGIT_NUM - 1) new_seg[i] = 7'h79;
      end else begin
        if (i <= top)                   new_seg[i] = bcd_to_seg(sh_value_q[i*4 +: 4]);
        else if (neg && (i == top + 1)) new_seg[i] = 7'h40;
        new_dp[i] = (sh_dp_q != 3'd0) && (i == int'(sh_dp_q));
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    err_d       = err_q;
    idx_d       = idx_q;
    msd_d       = msd_q;
    found_d     = found_q;
    bad_d       = bad_q;
    sh_value_d  = sh_value_q;
    sh_sign_d   = sh_sign_q;
    sh_dp_d     = sh_dp_q;
    frame_seg_d = frame_seg_q;
    frame_dp_d  = frame_dp_q;
    nib         = sh_value_q[int'(idx_q)*4 +: 4];
    case (state_q)
      IDLE: begin
        if (rif.load && ready_q) begin
          sh_value_d = rif.value;
          sh_sign_d  = rif.value_sign;
          sh_dp_d    = rif.value_dp;
          ready_d    = 1'b0;
          idx_d      = IDX_W'(DIGIT_NUM - 1);
          msd_d      = '0;
          found_d    = 1'b0;
          bad_d      = 1'b0;
          state_d    = ANALYZE;
        end
      end
      ANALYZE: begin
        if (nib > 4'd9) bad_d = 1'b1;
        // Walking down from the MSD, the first nonzero nibble seen is the highest one.
        if (!found_q && (nib != 4'd0)) begin
          found_d = 1'b1;
          msd_d   = idx_q;
        end
        if (idx_q == '0) state_d = COMMIT;
        else             idx_d   = idx_q - IDX_W'(1);
      end
      COMMIT: begin
        frame_seg_d = new_seg;
        frame_dp_d  = new_dp;
        err_d       = frame_error;
        ready_d     = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Display registers pick from the next frame so a commit shows on the same edge.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    scan_d = scan_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d  = '0;
      scan_d = (scan_q == IDX_W'(DIGIT_NUM - 1)) ? '0 : scan_q + IDX_W'(1);
    end
    seg_d      = frame_seg_d[scan_d];
    seg_dp_d   = frame_dp_d[scan_d];
    digit_en_d = DIGIT_NUM'(1) << scan_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      idx_q       <= '0;
      msd_q       <= '0;
      found_q     <= 1'b0;
      bad_q       <= 1'b0;
      sh_value_q  <= '0;
      sh_sign_q   <= 1'b0;
      sh_dp_q     <= '0;
      frame_seg_q <= '0;
      frame_dp_q  <= '0;
      cnt_q       <= '0;
      scan_q      <= '0;
      seg_q       <= '0;
      seg_dp_q    <= 1'b0;
      digit_en_q  <= DIGIT_NUM'(1);
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      msd_q       <= msd_d;
      found_q     <= found_d;
      bad_q       <= bad_d;
      sh_value_q  <= sh_value_d;
      sh_sign_q   <= sh_sign_d;
      sh_dp_q     <= sh_dp_d;
      frame_seg_q <= frame_seg_d;
      frame_dp_q  <= frame_dp_d;
      cnt_q       <= cnt_d;
      scan_q      <= scan_d;
      seg_q       <= seg_d;
      seg_dp_q    <= seg_dp_d;
      digit_en_q  <= digit_en_d;
    end
  end

  assign rif.ready = ready_q;
  assign rif.err   = err_q;
  assign seg       = seg_q;
  assign seg_dp    = seg_dp_q;
  assign digit_en  = digit_en_q;

endmodule

// File: doc/result_display_scan.md
Name: result_display_scan

Overview:
- Consumer end of the calculator ALU result interface. Takes a BCD magnitude, a sign and a decimal-point position, and drives a time-multiplexed 7-segment display.
- On each accepted load it runs a sequential per-digit analysis that does leading-zero suppression, sign placement and error detection. It then commits the new frame atomically.
- A free-running refresh counter scans the digits continuously.
- It sits between the ALU result register and the board display pins.

Parameters:
- DIGIT_NUM, 8, number of BCD digits and display positions.
- REFRESH_DIV, 1000, clock cycles each digit stays enabled; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  request to display a new value; accepted when load and ready are both 1 on a clock edge.
- value  input  DIGIT_NUM*4  BCD magnitude; digit 0 is the least significant (bits 3:0).
- value_sign  input  1  1 means negative.
- value_dp  input  3  number of fractional digits.
- ready  output  1  block can accept a load.
- err  output  1  the committed frame is an error frame.
- seg  output  7  segments {g,f,e,d,c,b,a} for the enabled digit, active-high.
- seg_dp  output  1  decimal point of the enabled digit, active-high.
- digit_en  output  DIGIT_NUM  one-hot digit enable, active-high.

Behaviour:
- Reset (asynchronous on rst_n low):
  - ready=1, err=0, seg=0, seg_dp=0, digit_en=1 (digit 0).
  - Refresh counter=0; all frame registers blank; FSM in IDLE.
  - A reset during ANALYZE aborts it and leaves the frame blank.
- FSM states: IDLE, ANALYZE, COMMIT.
  - IDLE: on load & ready, capture value, value_sign and value_dp into shadow registers; set ready=0; go to ANALYZE with the index at DIGIT_NUM-1.
  - ANALYZE: examine one shadow digit per cycle, from the MSD down to digit 0, i.e. DIGIT_NUM cycles. Track the first nonzero digit and flag any nibble greater than 9.
  - COMMIT: one cycle that writes all frame registers and err; ready returns to 1 on the same edge; go to IDLE.
- Timing: load is accepted at edge N; ready is low for cycles N+1 through N+DIGIT_NUM+1. The frame and err change only at the COMMIT edge (N+DIGIT_NUM+1); the display never shows a partial frame.
- A load while ready=0 is ignored; it is neither queued nor latched.
- Frame rules, with msd = the highest nonzero digit index (0 if the value is all zero) and k = value_dp:
  - Shown digits are indices 0 through max(msd, k); all higher digits are blank (seg 0x00).
  - Decimal point: when k>0, seg_dp is lit on digit k only; when k=0, no point is lit.
  - Negative sign: when value_sign=1 and the value is nonzero, digit max(msd,k)+1 shows minus (0x40).
  - Negative zero: the sign is dropped and no minus is shown.
  - Error frame, err=1: raised if any nibble is greater than 9, or if a minus is needed but max(msd,k)=DIGIT_NUM-1. The frame shows 'E' (0x79) on digit DIGIT_NUM-1, all other digits blank, and no decimal point.
  - err is cleared at the next COMMIT of a valid frame.
- Segment codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Scan:
  - The refresh counter counts 0 to REFRESH_DIV-1. At the terminal count it wraps to 0 and the digit index increments; index DIGIT_NUM-1 wraps to 0.
  - digit_en, seg and seg_dp are registered and all reflect the same index; there is no cross-digit glitch.
  - Scanning never pauses, including during ANALYZE and COMMIT.

Test Plan:
- Reset with REFRESH_DIV=4: hold rst_n low, then release.
  - While low: digit_en=0x01, seg=0, ready=1, err=0.
  - After release: digit_en goes 0x01, 0x02, … 0x80, 0x01, changing every 4 cycles.
- Load value=0x00001234, sign=0, dp=0:
  - ready is low for exactly 9 cycles.
  - Digits 0–3 show 66, 4F, 5B, 06; digits 4–7 show 00; seg_dp is never set.
- Load value=0x00000005, sign=1, dp=2 ("-0.05"):
  - Digits 0–2 show 6D, 3F, 3F, with seg_dp on digit 2 only.
  - Digit 3 shows 40; digits 4–7 are blank.
- Error frames:
  - value=0x12345678 with sign=1 gives err=1: digit 7 shows 79, all others 00.
  - A following load of value=0x0000000A also gives err=1.
  - A following load of value=0x00000009 clears err and digit 0 shows 6F.
- Loads while busy:
  - A second load pulse while ready=0 is ignored; the frame reflects only the first value.
  - Negative zero (value=0, sign=1, dp=0) shows 3F on digit 0 with no minus.
- Reset mid-operation: assert rst_n low at ANALYZE cycle 4; after release the frame is blank, ready=1, err=0, and the previous frame is not restored.
